// File: rtl/lgn_frame_sequencer.sv
// Frame sequencer for the logic-gate-network datapath: loads pixel beats into the net
// input vector, waits for the net to settle, then holds the argmax result for a consumer.
module lgn_frame_sequencer #(
    parameter int INPUT_BITS    = 256,
    parameter int BYTE_W        = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int IDX_W         = 4,
    parameter int VAL_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  in_valid,
    input  logic [BYTE_W-1:0]     in_data,
    output logic                  in_ready,
    output logic [INPUT_BITS-1:0] x_out,
    input  logic [IDX_W-1:0]      net_index,
    input  logic [VAL_W-1:0]      net_value,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDX_W-1:0]      res_index,
    output logic [VAL_W-1:0]      res_value,
    output logic                  busy,
    output logic [7:0]            frames_done
);

    localparam int BEATS = INPUT_BITS / BYTE_W;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam int SET_W = 4;
    localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BEATS - 1);
    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [CNT_W-1:0]        beat_cnt_r;
    logic [SET_W-1:0]        settle_cnt_r;
    logic [INPUT_BITS-1:0]   x_out_r;
    logic                    res_valid_r;
    logic [IDX_W-1:0]        res_index_r;
    logic [VAL_W-1:0]        res_value_r;
    logic [7:0]              frames_done_r;

    logic                    beat_accept_s;
    logic                    last_beat_s;
    logic                    settle_done_s;
    logic                    res_take_s;

    // An abort that coincides with a beat makes that beat the first of a new frame,
    // so it can never also be the last beat of the old one.
    assign beat_accept_s = in_valid && (state_r == ST_LOAD);
    assign last_beat_s   = beat_accept_s && !frame_start && (beat_cnt_r == LAST_BEAT);
    assign settle_done_s = (state_r == ST_SETTLE) && (settle_cnt_r == {SET_W{1'b0}});
    assign res_take_s    = (state_r == ST_HOLD) && res_valid_r && res_ready && !frame_start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; frame_start overrides every transition.
    always_comb begin
        state_s = state_r;
        if (frame_start) begin
            state_s = ST_LOAD;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (last_beat_s) begin
                        state_s = ST_SETTLE;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (settle_done_s) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_SETTLE;
                    end
                end
                ST_HOLD: begin
                    if (res_take_s) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: state_s = ST_LOAD;
            endcase
        end
    end

    // Output decode from the state register only.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_r)
            ST_LOAD:   in_ready = 1'b1;
            ST_SETTLE: busy     = 1'b1;
            ST_HOLD:   busy     = 1'b1;
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // Beat counter and input shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= {CNT_W{1'b0}};
            x_out_r    <= {INPUT_BITS{1'b0}};
        end else begin
            if (beat_accept_s) begin
                x_out_r <= {x_out_r[INPUT_BITS-BYTE_W-1:0], in_data};
            end
            if (frame_start) begin
                beat_cnt_r <= beat_accept_s ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
            end else if (last_beat_s) begin
                beat_cnt_r <= {CNT_W{1'b0}};
            end else if (beat_accept_s) begin
                beat_cnt_r <= beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Settle countdown, armed by the final beat of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt_r <= {SET_W{1'b0}};
        end else if (last_beat_s) begin
            settle_cnt_r <= SETTLE_INIT;
        end else if ((state_r == ST_SETTLE) && (settle_cnt_r != {SET_W{1'b0}})) begin
            settle_cnt_r <= settle_cnt_r - {{(SET_W-1){1'b0}}, 1'b1};
        end
    end

    // Result capture and handshake; index/value keep their last capture after consumption.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r   <= 1'b0;
            res_index_r   <= {IDX_W{1'b0}};
            res_value_r   <= {VAL_W{1'b0}};
            frames_done_r <= 8'd0;
        end else begin
            if (frame_start) begin
                res_valid_r <= 1'b0;
            end else if (settle_done_s) begin
                res_valid_r <= 1'b1;
                res_index_r <= net_index;
                res_value_r <= net_value;
            end else if (res_take_s) begin
                res_valid_r   <= 1'b0;
                frames_done_r <= frames_done_r + 8'd1;
            end
        end
    end

    assign x_out       = x_out_r;
    assign res_valid   = res_valid_r;
    assign res_index   = res_index_r;
    assign res_value   = res_value_r;
    assign frames_done = frames_done_r;

endmodule

// File: tb/tb_lgn_frame_sequencer.sv
// Scoreboard bench for lgn_frame_sequencer: the stimulus pushes expected results, a monitor
// checks timing, values and frame counting whenever a result is presented.
module tb_lgn_frame_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         frame_start;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic [255:0] x_out;
    logic [3:0]   net_index;
    logic [7:0]   net_value;
    logic         res_valid;
    logic         res_ready;
    logic [3:0]   res_index;
    logic [7:0]   res_value;
    logic         busy;
    logic [7:0]   frames_done;

    always #5 clk = ~clk;

    lgn_frame_sequencer dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .x_out(x_out), .net_index(net_index),
        .net_value(net_value), .res_valid(res_valid), .res_ready(res_ready),
        .res_index(res_index), .res_value(res_value), .busy(busy), .frames_done(frames_done)
    );

    typedef struct {
        logic [255:0] x;
        logic [3:0]   idx;
        logic [7:0]   val;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [7:0]   fb [32];
    logic [255:0] saved_x;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pixel i of the frame occupies byte lane 31-i of the net input.
    function automatic logic [255:0] frame_vec();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[255 - 8*i -: 8] = fb[i];
        return v;
    endfunction

    // Monitor: samples just after the negedge, once stimulus has settled.
    logic [7:0] exp_done = 8'd0;
    logic       prev_valid = 1'b0;
    logic       prev_hs = 1'b0;
    always @(negedge clk) begin
        logic hs;
        #1;
        if (!rst_n) begin
            sb.delete();
            exp_done   = 8'd0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (res_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", res_valid, 1'b0);
                end else begin
                    if (!prev_valid) check("settle_latency", cyc - sb[0].acc, 2);
                    check("res_index", res_index, sb[0].idx);
                    check("res_value", res_value, sb[0].val);
                    check("x_out_frame", x_out, sb[0].x);
                end
            end else if (prev_valid && !prev_hs && sb.size() > 0) begin
                void'(sb.pop_front());
            end
            hs = res_valid && res_ready && !frame_start;
            if (hs) begin
                check("frames_done_pre", frames_done, exp_done);
                if (sb.size() > 0) void'(sb.pop_front());
                exp_done = exp_done + 8'd1;
            end
            prev_valid = res_valid;
            prev_hs    = hs;
        end
    end

    int last_acc;

    task automatic drive_beat(input logic [7:0] b, input logic fs, input int gap);
        in_valid    = 1'b1;
        in_data     = b;
        frame_start = fs;
        check("in_ready_load", in_ready, 1'b1);
        last_acc = cyc + 1;
        @(negedge clk);
        in_valid    = 1'b0;
        frame_start = 1'b0;
        repeat (gap) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
    endtask

    // gap_mode: 0 back-to-back, 1 alternate valid, 2 random idle cycles.
    task automatic send_frame(input int pre_junk, input int gap_mode, input bit push);
        exp_t e;
        int   g;
        for (int i = 0; i < pre_junk; i++) drive_beat(8'($urandom), 1'b0, 0);
        for (int i = 0; i < 32; i++) begin
            g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            if (i == 31) begin
                g = 0;
                if (push) begin
                    e.x   = frame_vec();
                    e.idx = net_index;
                    e.val = net_value;
                    e.acc = cyc + 1;
                    sb.push_back(e);
                end
            end
            drive_beat(fb[i], (i == 0) && (pre_junk > 0), g);
        end
    endtask

    task automatic wait_done(input logic [7:0] target, input bit rnd);
        for (int k = 0; k < 400; k++) begin
            if (frames_done == target) break;
            if (rnd) res_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("frames_done_wait", frames_done, target);
    endtask

    task automatic wait_res_valid();
        for (int k = 0; k < 100; k++) begin
            if (res_valid) break;
            @(negedge clk);
        end
        check("res_valid_wait", res_valid, 1'b1);
    endtask

    task automatic randomize_frame();
        for (int i = 0; i < 32; i++) fb[i] = 8'($urandom);
        net_index = 4'($urandom);
        net_value = 8'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        net_index = 4'd0; net_value = 8'd0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_x_out", x_out, 256'd0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_index", res_index, 4'd0);
        check("rst_res_value", res_value, 8'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_frames_done", frames_done, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp frame, back-to-back beats, consumer always ready.
        for (int i = 0; i < 32; i++) fb[i] = 8'(i);
        net_index = 4'd7; net_value = 8'h5A; res_ready = 1'b1;
        send_frame(0, 0, 1'b1);
        wait_done(8'd1, 1'b0);
        check("t1_x_top", x_out[255:248], 8'h00);
        check("t1_x_bot", x_out[7:0], 8'h1F);
        check("t1_in_ready", in_ready, 1'b1);

        // Same ramp with valid toggling every cycle.
        net_index = 4'($urandom); net_value = 8'($urandom);
        send_frame(0, 1, 1'b1);
        wait_done(8'd2, 1'b0);
        for (int i = 0; i < 32; i++) fb[i] = 8'(i);
        check("t2_x_out", x_out, frame_vec());

        // Back-pressure in HOLD: beats ignored, result stable.
        res_ready = 1'b0;
        randomize_frame();
        send_frame(0, 2, 1'b1);
        wait_res_valid();
        saved_x = x_out;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
            check("t3_in_ready", in_ready, 1'b0);
            check("t3_busy", busy, 1'b1);
            check("t3_x_frozen", x_out, saved_x);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        wait_done(8'd3, 1'b0);
        check("t3_res_valid_low", res_valid, 1'b0);

        // Abort after 10 beats with a beat in the same cycle.
        randomize_frame();
        fb[0] = 8'hAA;
        send_frame(10, 0, 1'b1);
        wait_done(8'd4, 1'b0);
        check("t4_x_top", x_out[255:248], 8'hAA);

        // Abort during SETTLE: no result, x_out kept.
        randomize_frame();
        send_frame(0, 0, 1'b0);
        check("t5_busy_settle", busy, 1'b1);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("t5s_in_ready", in_ready, 1'b1);
        check("t5s_busy", busy, 1'b0);
        repeat (5) @(negedge clk);
        check("t5s_res_valid", res_valid, 1'b0);
        check("t5s_frames_done", frames_done, 8'd4);
        check("t5s_x_kept", x_out, frame_vec());

        // Abort during HOLD together with res_ready: abort wins.
        res_ready = 1'b0;
        randomize_frame();
        send_frame(0, 0, 1'b1);
        wait_res_valid();
        repeat (3) @(negedge clk);
        frame_start = 1'b1;
        res_ready   = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        res_ready   = 1'b0;
        check("t5h_res_valid", res_valid, 1'b0);
        check("t5h_in_ready", in_ready, 1'b1);
        repeat (3) @(negedge clk);
        check("t5h_frames_done", frames_done, 8'd4);

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 10; i++) drive_beat(8'($urandom), 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t5r_x_out", x_out, 256'd0);
        check("t5r_res_index", res_index, 4'd0);
        check("t5r_res_value", res_value, 8'd0);
        check("t5r_res_valid", res_valid, 1'b0);
        check("t5r_frames_done", frames_done, 8'd0);
        check("t5r_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 256 random frames: frames_done wraps back to zero.
        for (int f = 0; f < 256; f++) begin
            randomize_frame();
            send_frame(0, 2, 1'b1);
            wait_done(8'(f + 1), 1'b1);
        end
        check("t6_wrap", frames_done, 8'd0);
        res_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
